// File: rtl/ccg_pkg.sv
// ----------------------------------------------------------------------------
// ccg_pkg
// Shared definitions for the CCGRCG truth-table sweep controller.
//   sweep_state_e      : controller FSM encoding
//   MISR_POLY_DEFAULT  : default MISR feedback taps for a 10-bit output CUT
// ----------------------------------------------------------------------------
package ccg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_EMIT,
      ST_DONE
   } sweep_state_e;

   localparam logic [9:0] MISR_POLY_DEFAULT = 10'h204;

endpackage

// File: rtl/ccg_misr.sv
// ----------------------------------------------------------------------------
// ccg_misr
// Multiple-input signature register compacting every captured CUT row.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, clears the signature
//   clr    : clear signature to 0 (priority over en)
//   en     : fold d into the signature this cycle
//   d      : captured CUT output row
//   sig    : current signature
// ----------------------------------------------------------------------------
module ccg_misr #(
   parameter int               N_OUT = 10,
   parameter logic [N_OUT-1:0] POLY  = 10'h204
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [N_OUT-1:0] d,
   output logic [N_OUT-1:0] sig
);

   logic [N_OUT-1:0] sig_reg;
   logic [N_OUT-1:0] sig_next;
   logic             fb;

   assign fb = sig_reg[N_OUT-1];

   // Shift left by one, fold in the taps when the MSB falls out, then xor the row.
   generate
      for (genvar gi = 0; gi < N_OUT; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign sig_next[gi] = (fb & POLY[gi]) ^ d[gi];
         end else begin : g_upper
            assign sig_next[gi] = sig_reg[gi-1] ^ (fb & POLY[gi]) ^ d[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_reg <= '0;
      end else if (clr) begin
         sig_reg <= '0;
      end else if (en) begin
         sig_reg <= sig_next;
      end
   end

   assign sig = sig_reg;

endmodule

// File: rtl/ccg_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ccg_sweep_ctrl
// Exhaustive truth-table sequencer for one combinational CUT. Walks cut_x
// through 0 .. 2^N_IN-1, waits SETTLE cycles per vector, captures cut_f and
// presents each row on a valid/ready stream.
// Optional feature macro: CCG_SWEEP_MISR_EN adds the MISR and signature port.
// Ports:
//   clk, rst_n           : clock / synchronous active-low reset
//   start, abort         : begin sweep (IDLE only) / cancel sweep (no done)
//   busy, done           : sweep in progress / one-cycle end-of-sweep pulse
//   cut_x, cut_f         : vector to CUT / CUT response
//   row_valid, row_ready : row stream handshake
//   row_idx, row_data    : vector index and captured response of the row
//   signature            : MISR result (CCG_SWEEP_MISR_EN only)
// ----------------------------------------------------------------------------
module ccg_sweep_ctrl
   import ccg_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 10,
   parameter int SETTLE = 1
`ifdef CCG_SWEEP_MISR_EN
   ,
   parameter logic [N_OUT-1:0] MISR_POLY = N_OUT'(MISR_POLY_DEFAULT)
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [N_IN-1:0]  cut_x,
   input  logic [N_OUT-1:0] cut_f,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [N_IN-1:0]  row_idx,
   output logic [N_OUT-1:0] row_data
`ifdef CCG_SWEEP_MISR_EN
   ,
   output logic [N_OUT-1:0] signature
`endif
);

   localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);
   // vec carries one extra bit so the last index compares without wrapping.
   localparam logic [N_IN:0]    VEC_LAST = (N_IN + 1)'((1 << N_IN) - 1);

   sweep_state_e     state_reg;
   sweep_state_e     state_next;
   logic [N_IN:0]    vec_reg;
   logic [N_IN:0]    vec_plus;
   logic [CNT_W-1:0] cnt_reg;
   logic [N_IN-1:0]  cut_x_reg;
   logic [N_IN-1:0]  row_idx_reg;
   logic [N_OUT-1:0] row_data_reg;
   logic             abort_hit;

   assign abort_hit = abort && (state_reg != ST_IDLE);
   assign vec_plus  = vec_reg + (N_IN + 1)'(1);

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      if (abort_hit) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:   if (start) state_next = ST_SETTLE;
            ST_SETTLE: if (cnt_reg == '0) state_next = ST_EMIT;
            ST_EMIT:   if (row_ready) state_next = (vec_reg == VEC_LAST) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      busy      = (state_reg != ST_IDLE);
      done      = (state_reg == ST_DONE);
      row_valid = (state_reg == ST_EMIT);
   end

   // ---------------- datapath: vector, settle counter, row capture ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_reg      <= '0;
         cnt_reg      <= '0;
         cut_x_reg    <= '0;
         row_idx_reg  <= '0;
         row_data_reg <= '0;
      end else if (abort_hit) begin
         cut_x_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  vec_reg   <= '0;
                  cut_x_reg <= '0;
                  cnt_reg   <= CNT_INIT;
               end
            end
            ST_SETTLE: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else begin
                  row_data_reg <= cut_f;
                  row_idx_reg  <= vec_reg[N_IN-1:0];
               end
            end
            ST_EMIT: begin
               if (row_ready && (vec_reg != VEC_LAST)) begin
                  vec_reg   <= vec_plus;
                  cut_x_reg <= vec_plus[N_IN-1:0];
                  cnt_reg   <= CNT_INIT;
               end
            end
            ST_DONE: begin
               cut_x_reg <= '0;
            end
            default: begin
               cut_x_reg <= '0;
            end
         endcase
      end
   end

   assign cut_x    = cut_x_reg;
   assign row_idx  = row_idx_reg;
   assign row_data = row_data_reg;

`ifdef CCG_SWEEP_MISR_EN
   logic start_acc;
   logic capture_en;

   assign start_acc  = (state_reg == ST_IDLE) && start;
   assign capture_en = (state_reg == ST_SETTLE) && (cnt_reg == '0) && !abort;

   ccg_misr #(
      .N_OUT (N_OUT),
      .POLY  (MISR_POLY)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_acc),
      .en    (capture_en),
      .d     (cut_f),
      .sig   (signature)
   );
`endif

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ccg_sweep_ctrl
// Directed bench for ccg_sweep_ctrl. Instance u_a uses SETTLE=1 with a
// selectable CUT model, instance u_b uses SETTLE=0 with a loopback CUT.
// ----------------------------------------------------------------------------
module tb_ccg_sweep_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cut_mode = 0;   // 0 loopback, 1 zero, 2 one, 3 all-ones

   logic       a_rst_n, a_start, a_abort, a_row_ready;
   logic       a_busy, a_done, a_row_valid;
   logic [2:0] a_cut_x, a_row_idx;
   logic [9:0] a_cut_f, a_row_data;

   logic       b_rst_n, b_start, b_abort, b_row_ready;
   logic       b_busy, b_done, b_row_valid;
   logic [2:0] b_cut_x, b_row_idx;
   logic [9:0] b_cut_f, b_row_data;

`ifdef CCG_SWEEP_MISR_EN
   logic [9:0] a_sig, b_sig;
`endif

   assign a_cut_f = (cut_mode == 0) ? {7'b0, a_cut_x} :
                    (cut_mode == 1) ? 10'h000 :
                    (cut_mode == 2) ? 10'h001 : 10'h3FF;
   assign b_cut_f = {7'b0, b_cut_x};

   ccg_sweep_ctrl #(.N_IN(3), .N_OUT(10), .SETTLE(1)) u_a (
      .clk(clk), .rst_n(a_rst_n), .start(a_start), .abort(a_abort),
      .busy(a_busy), .done(a_done), .cut_x(a_cut_x), .cut_f(a_cut_f),
      .row_valid(a_row_valid), .row_ready(a_row_ready),
      .row_idx(a_row_idx), .row_data(a_row_data)
`ifdef CCG_SWEEP_MISR_EN
      , .signature(a_sig)
`endif
   );

   ccg_sweep_ctrl #(.N_IN(3), .N_OUT(10), .SETTLE(0)) u_b (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .abort(b_abort),
      .busy(b_busy), .done(b_done), .cut_x(b_cut_x), .cut_f(b_cut_f),
      .row_valid(b_row_valid), .row_ready(b_row_ready),
      .row_idx(b_row_idx), .row_data(b_row_data)
`ifdef CCG_SWEEP_MISR_EN
      , .signature(b_sig)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] exp_data(input int mode, input int idx);
      case (mode)
         0:       return 10'(idx);
         1:       return 10'h000;
         2:       return 10'h001;
         default: return 10'h3FF;
      endcase
   endfunction

   // Start a sweep on u_a and record timing relative to the start cycle.
   task automatic sweep_a(output int first_c, output int done_c,
                          output int nrows, output int bad, output int ndone);
      first_c = -1; done_c = -1; nrows = 0; bad = 0; ndone = 0;
      a_row_ready = 1'b1;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (a_row_valid && a_row_ready) begin
            $display("A row idx=%0d data=%h cyc=%0d", a_row_idx, a_row_data, cyc);
            if (a_row_idx !== 3'(nrows) || a_row_data !== exp_data(cut_mode, nrows)) bad++;
            if (first_c < 0) first_c = cyc;
            nrows++;
         end
         if (a_done) begin
            ndone++;
            done_c = cyc;
         end
         if (done_c >= 0 && cyc >= done_c + 3) break;
         tick();
      end
   endtask

   task automatic sweep_b(output int first_c, output int done_c,
                          output int nrows, output int bad, output int ndone);
      first_c = -1; done_c = -1; nrows = 0; bad = 0; ndone = 0;
      b_row_ready = 1'b1;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (b_row_valid && b_row_ready) begin
            $display("B row idx=%0d data=%h cyc=%0d", b_row_idx, b_row_data, cyc);
            if (b_row_idx !== 3'(nrows) || b_row_data !== 10'(nrows)) bad++;
            if (first_c < 0) first_c = cyc;
            nrows++;
         end
         if (b_done) begin
            ndone++;
            done_c = cyc;
         end
         if (done_c >= 0 && cyc >= done_c + 3) break;
         tick();
      end
   endtask

   task automatic wait_row_a(input int idx, output int found);
      found = 0;
      for (int i = 0; i < 60; i++) begin
         if (a_row_valid && a_row_idx == 3'(idx)) begin
            found = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_done_a(output int found);
      found = 0;
      for (int i = 0; i < 60; i++) begin
         if (a_done) begin
            found = 1;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_row_ready = 1'b1;
      b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_row_ready = 1'b1;
      tick(); tick();
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      checks++;
      if ({a_busy, a_done, a_row_valid, a_cut_x, a_row_idx, a_row_data} !== 17'h0) begin
         errors++;
         $display("FAIL reset_a got busy=%b done=%b valid=%b x=%h idx=%h data=%h want all 0",
                  a_busy, a_done, a_row_valid, a_cut_x, a_row_idx, a_row_data);
      end
      checks++;
      if ({b_busy, b_done, b_row_valid, b_cut_x, b_row_idx, b_row_data} !== 17'h0) begin
         errors++;
         $display("FAIL reset_b got busy=%b done=%b valid=%b x=%h idx=%h data=%h want all 0",
                  b_busy, b_done, b_row_valid, b_cut_x, b_row_idx, b_row_data);
      end
`ifdef CCG_SWEEP_MISR_EN
      checks++;
      if (a_sig !== 10'h0) begin
         errors++;
         $display("FAIL reset_sig got %h want 000", a_sig);
      end
`endif
      $display("reset done");
   endtask

   task automatic test_loopback();
      int f, d, n, bad, nd;
      cut_mode = 0;
      sweep_a(f, d, n, bad, nd);
      checks++; if (f !== 3)   begin errors++; $display("FAIL loop_first got %0d want 3", f); end
      checks++; if (d !== 25)  begin errors++; $display("FAIL loop_done got %0d want 25", d); end
      checks++; if (n !== 8)   begin errors++; $display("FAIL loop_rows got %0d want 8", n); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL loop_data got %0d bad rows want 0", bad); end
      checks++; if (nd !== 1)  begin errors++; $display("FAIL loop_done_pulses got %0d want 1", nd); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL loop_busy_end got %b want 0", a_busy); end
   endtask

   task automatic test_backpressure();
      int found;
      cut_mode = 0;
      a_row_ready = 1'b1;
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_row_a(3, found);
      checks++; if (found !== 1) begin errors++; $display("FAIL bp_reach_row3 got %0d want 1", found); end
      a_row_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (a_row_valid !== 1'b1 || a_row_idx !== 3'd3 || a_row_data !== 10'd3 || a_cut_x !== 3'd3) begin
            errors++;
            $display("FAIL bp_hold%0d got valid=%b idx=%0d data=%0d x=%0d want 1 3 3 3",
                     i, a_row_valid, a_row_idx, a_row_data, a_cut_x);
         end
         tick();
      end
      a_row_ready = 1'b1;
      $display("bp handshake row3 valid=%b", a_row_valid);
      tick(); tick();
      checks++; if (a_row_valid !== 1'b0) begin errors++; $display("FAIL bp_gap got valid=%b want 0", a_row_valid); end
      tick();
      checks++;
      if (a_row_valid !== 1'b1 || a_row_idx !== 3'd4 || a_row_data !== 10'd4) begin
         errors++;
         $display("FAIL bp_row4 got valid=%b idx=%0d data=%0d want 1 4 4", a_row_valid, a_row_idx, a_row_data);
      end
      wait_done_a(found);
      checks++; if (found !== 1) begin errors++; $display("FAIL bp_done got %0d want 1", found); end
   endtask

   task automatic test_start_abort();
      int found, spurious, f, d, n, bad, nd;
      cut_mode = 0;
      a_row_ready = 1'b1;
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_row_a(2, found);
      a_start = 1'b1; tick(); a_start = 1'b0;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (a_row_valid) begin found = 1; break; end
         tick();
      end
      checks++;
      if (found !== 1 || a_row_idx !== 3'd3 || a_row_data !== 10'd3) begin
         errors++;
         $display("FAIL sa_after_start got found=%0d idx=%0d data=%0d want 1 3 3", found, a_row_idx, a_row_data);
      end
      tick();
      checks++; if (a_cut_x !== 3'd4 || a_busy !== 1'b1) begin
         errors++; $display("FAIL sa_settle4 got x=%0d busy=%b want 4 1", a_cut_x, a_busy);
      end
      a_abort = 1'b1; tick(); a_abort = 1'b0;
      $display("abort issued");
      checks++;
      if (a_busy !== 1'b0 || a_cut_x !== 3'd0 || a_row_valid !== 1'b0 || a_done !== 1'b0) begin
         errors++;
         $display("FAIL sa_abort got busy=%b x=%0d valid=%b done=%b want 0 0 0 0",
                  a_busy, a_cut_x, a_row_valid, a_done);
      end
      spurious = 0;
      for (int i = 0; i < 10; i++) begin
         if (a_done || a_busy || a_row_valid) spurious++;
         tick();
      end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL sa_idle got %0d active cycles want 0", spurious); end
      sweep_a(f, d, n, bad, nd);
      checks++;
      if (f !== 3 || n !== 8 || bad !== 0 || d !== 25) begin
         errors++;
         $display("FAIL sa_restart got first=%0d rows=%0d bad=%0d done=%0d want 3 8 0 25", f, n, bad, d);
      end
   endtask

   task automatic test_reset_mid();
      int found, f, d, n, bad, nd;
      cut_mode = 0;
      a_row_ready = 1'b1;
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_row_a(5, found);
      a_row_ready = 1'b0;
      tick();
      a_rst_n = 1'b0; tick(); a_rst_n = 1'b1;
      $display("mid-sweep reset applied");
      checks++;
      if ({a_busy, a_done, a_row_valid, a_cut_x, a_row_idx, a_row_data} !== 17'h0) begin
         errors++;
         $display("FAIL rm_outputs got busy=%b done=%b valid=%b x=%h idx=%h data=%h want all 0",
                  a_busy, a_done, a_row_valid, a_cut_x, a_row_idx, a_row_data);
      end
      sweep_a(f, d, n, bad, nd);
      checks++;
      if (f !== 3 || n !== 8 || bad !== 0 || d !== 25 || nd !== 1) begin
         errors++;
         $display("FAIL rm_sweep got first=%0d rows=%0d bad=%0d done=%0d pulses=%0d want 3 8 0 25 1",
                  f, n, bad, d, nd);
      end
   endtask

   task automatic test_settle0();
      int f, d, n, bad, nd;
      sweep_b(f, d, n, bad, nd);
      checks++; if (f !== 2)   begin errors++; $display("FAIL s0_first got %0d want 2", f); end
      checks++; if (d !== 17)  begin errors++; $display("FAIL s0_done got %0d want 17", d); end
      checks++; if (n !== 8 || bad !== 0 || nd !== 1) begin
         errors++; $display("FAIL s0_rows got rows=%0d bad=%0d pulses=%0d want 8 0 1", n, bad, nd);
      end
   endtask

`ifdef CCG_SWEEP_MISR_EN
   task automatic test_misr();
      int f, d, n, bad, nd, found;
      logic [9:0] model;
      for (int m = 2; m <= 3; m++) begin
         cut_mode = m;
         model = 10'h0;
         for (int i = 0; i < 8; i++)
            model = {model[8:0], 1'b0} ^ (model[9] ? 10'h204 : 10'h000) ^ exp_data(m, i);
         sweep_a(f, d, n, bad, nd);
         checks++; if (a_sig !== model) begin errors++; $display("FAIL misr_mode%0d got %h want %h", m, a_sig, model); end
         tick(); tick(); tick();
         checks++; if (a_sig !== model) begin errors++; $display("FAIL misr_hold%0d got %h want %h", m, a_sig, model); end
      end
      cut_mode = 1;
      a_row_ready = 1'b1;
      a_start = 1'b1; tick(); a_start = 1'b0;
      checks++; if (a_sig !== 10'h0) begin errors++; $display("FAIL misr_clear got %h want 000", a_sig); end
      wait_done_a(found);
      checks++; if (found !== 1 || a_sig !== 10'h0) begin
         errors++; $display("FAIL misr_zero got found=%0d sig=%h want 1 000", found, a_sig);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_loopback();
      test_backpressure();
      test_start_abort();
      test_reset_mid();
      test_settle0();
`ifdef CCG_SWEEP_MISR_EN
      test_misr();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
